// File: rtl/sd_sector_cache.sv
// Two-buffer (ping-pong) sector cache in front of the SD controller byte-read port.
// Missing sectors are fetched over a request/stream handshake, with optional next-sector prefetch.
module sd_sector_cache #(
    parameter int SECTOR_BYTES = 512,
    parameter int SEC_W        = 55,
    parameter bit PREFETCH     = 1'b1
) (
    input  logic             rdclk,
    input  logic             rst,
    input  logic [63:0]      rdaddr,
    input  logic             rden,
    output logic [7:0]       rddata,
    output logic             rdhit,
    output logic             bk_req,
    output logic [SEC_W-1:0] bk_sector,
    input  logic             bk_ack,
    input  logic             bk_valid,
    input  logic [7:0]       bk_data,
    output logic             bk_ready,
    output logic             busy
);
    localparam int OFF_W = $clog2(SECTOR_BYTES);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t             state_reg;
    logic [1:0]         valid_reg;
    logic [SEC_W-1:0]   tag_reg [2];
    logic               last_used_reg;
    logic               have_hit_reg;
    logic [SEC_W-1:0]   last_sec_reg;
    logic               target_reg;
    logic [OFF_W-1:0]   cnt_reg;
    logic               rd_seen_reg;
    logic [7:0]         ram_q;
    logic [7:0]         mem [0:2*SECTOR_BYTES-1];

    logic [SEC_W-1:0]   sec;
    logic [OFF_W-1:0]   off;
    logic [1:0]         hit_vec;
    logic [1:0]         holds_next;
    logic               hit;
    logic               hit_buf;
    logic               eff_lu;
    logic [SEC_W-1:0]   eff_sec;
    logic [SEC_W-1:0]   next_sec;
    logic               demand;
    logic               prefetch;
    logic               fill_buf;
    logic               wr_en;
    logic               last_byte;

    assign sec = rdaddr[63:OFF_W];
    assign off = rdaddr[OFF_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            assign hit_vec[gi]    = rden && valid_reg[gi] && (tag_reg[gi] == sec);
            assign holds_next[gi] = valid_reg[gi] && (tag_reg[gi] == next_sec);
        end
    endgenerate

    assign hit      = |hit_vec;
    assign hit_buf  = hit_vec[1];
    // A hit in this cycle counts as the most recent use, so it is never chosen as the victim.
    assign eff_lu   = hit ? hit_buf : last_used_reg;
    assign eff_sec  = hit ? sec : last_sec_reg;
    assign next_sec = eff_sec + SEC_W'(1);
    assign demand   = rden && !hit;
    assign prefetch = PREFETCH && (hit || have_hit_reg) && !(|holds_next);
    assign fill_buf = ~eff_lu;
    assign wr_en     = (state_reg == FILL) && bk_valid && bk_ready;
    assign last_byte = (cnt_reg == OFF_W'(SECTOR_BYTES - 1));

    // rd_seen keeps rddata at zero after reset until the first real hit.
    assign rddata = rd_seen_reg ? ram_q : 8'h00;

    always_ff @(posedge rdclk) begin
        if (wr_en) begin
            mem[{target_reg, cnt_reg}] <= bk_data;
        end
        if (hit) begin
            ram_q <= mem[{hit_buf, off}];
        end
    end

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            valid_reg     <= 2'b00;
            tag_reg[0]    <= '0;
            tag_reg[1]    <= '0;
            last_used_reg <= 1'b0;
            have_hit_reg  <= 1'b0;
            last_sec_reg  <= '0;
            target_reg    <= 1'b0;
            cnt_reg       <= '0;
            rd_seen_reg   <= 1'b0;
            rdhit         <= 1'b0;
            bk_req        <= 1'b0;
            bk_sector     <= '0;
            bk_ready      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rdhit <= hit;
            if (hit) begin
                rd_seen_reg   <= 1'b1;
                last_used_reg <= hit_buf;
                last_sec_reg  <= sec;
                have_hit_reg  <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (demand || prefetch) begin
                        target_reg          <= fill_buf;
                        valid_reg[fill_buf] <= 1'b0;
                        tag_reg[fill_buf]   <= demand ? sec : next_sec;
                        bk_sector           <= demand ? sec : next_sec;
                        bk_req              <= 1'b1;
                        busy                <= 1'b1;
                        state_reg           <= REQ;
                    end
                end
                REQ: begin
                    if (bk_ack) begin
                        bk_req    <= 1'b0;
                        cnt_reg   <= '0;
                        bk_ready  <= 1'b1;
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        cnt_reg <= cnt_reg + OFF_W'(1);
                        if (last_byte) begin
                            valid_reg[target_reg] <= 1'b1;
                            busy                  <= 1'b0;
                            bk_ready              <= 1'b0;
                            state_reg             <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_cache.sv
// Scoreboard bench for sd_sector_cache: expected read bytes and expected backing
// requests are queued by the stimulus and consumed as the DUT produces them.
module tb_sd_sector_cache;
    localparam int SECTOR_BYTES = 512;
    localparam int SEC_W        = 55;

    logic             rdclk = 1'b0;
    logic             rst   = 1'b1;
    logic [63:0]      rdaddr;
    logic             rden;
    logic [7:0]       rddata;
    logic             rdhit;
    logic             bk_req;
    logic [SEC_W-1:0] bk_sector;
    logic             bk_ack;
    logic             bk_valid;
    logic [7:0]       bk_data;
    logic             bk_ready;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]       sb_q[$];
    logic [SEC_W-1:0] exp_sec_q[$];
    bit               gaps = 1'b0;
    int               bk_cnt = 0;

    sd_sector_cache #(.SECTOR_BYTES(SECTOR_BYTES), .SEC_W(SEC_W), .PREFETCH(1'b1)) dut (
        .rdclk(rdclk), .rst(rst), .rdaddr(rdaddr), .rden(rden), .rddata(rddata),
        .rdhit(rdhit), .bk_req(bk_req), .bk_sector(bk_sector), .bk_ack(bk_ack),
        .bk_valid(bk_valid), .bk_data(bk_data), .bk_ready(bk_ready), .busy(busy)
    );

    always #5 rdclk = ~rdclk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [SEC_W-1:0] s, input int i);
        return s[7:0] ^ 8'(i);
    endfunction

    function automatic logic [7:0] model(input logic [63:0] a);
        return pat(a[63:9], int'(a[8:0]));
    endfunction

    // One read cycle: queue the expected byte, sample one cycle later, compare on hit.
    task automatic cycle_rd(input logic [63:0] a, input bit must_hit, output bit got);
        logic [7:0] e;
        rdaddr = a;
        rden   = 1'b1;
        sb_q.push_back(model(a));
        @(posedge rdclk); #1;
        e   = sb_q.pop_front();
        got = rdhit;
        if (must_hit) check_val("rdhit", 64'(rdhit), 64'd1);
        if (rdhit) check_val("rddata", 64'(rddata), 64'(e));
        rden = 1'b0;
    endtask

    // Re-present an address until it hits; optionally interleave must-hit reads while busy.
    task automatic rd_wait(input logic [63:0] a, input logic [63:0] alt, input bit use_alt);
        bit got;
        bit g2;
        int tries;
        got   = 1'b0;
        tries = 0;
        while (!got && tries < 4000) begin
            cycle_rd(a, 1'b0, got);
            tries++;
            if (!got && use_alt && busy) cycle_rd(alt, 1'b1, g2);
        end
        check_val("rd_wait_hit", 64'(got), 64'd1);
        $display("read addr=%h data=%h tries=%0d", a, rddata, tries);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 4000) begin
            @(posedge rdclk); #1;
            k++;
        end
        check_val("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Backing store: acks each request one cycle late, then streams the sector.
    initial begin : bk_model
        logic [SEC_W-1:0] cur;
        int  n;
        bit  gap;
        bit  acc;
        bit  aborted;
        bk_ack   = 1'b0;
        bk_valid = 1'b0;
        bk_data  = 8'h00;
        forever begin
            @(posedge rdclk); #1;
            if (bk_req && !rst) begin
                if (exp_sec_q.size() == 0) check_val("unexpected_req", 64'(bk_req), 64'd0);
                else check_val("bk_sector", 64'(bk_sector), 64'(exp_sec_q.pop_front()));
                cur = bk_sector;
                $display("backing request sector=%0h", cur);
                @(posedge rdclk); #1;
                check_val("req_held", 64'(bk_req), 64'd1);
                bk_ack = 1'b1;
                @(posedge rdclk); #1;
                bk_ack  = 1'b0;
                bk_cnt  = 0;
                n       = 0;
                aborted = 1'b0;
                while (bk_cnt < SECTOR_BYTES && !aborted) begin
                    if (rst) begin
                        aborted = 1'b1;
                    end else begin
                        gap      = gaps && (n % 7 == 6);
                        bk_valid = !gap;
                        bk_data  = pat(cur, bk_cnt);
                        acc      = bk_valid && bk_ready;
                        if (gap) check_val("busy_gap", 64'(busy), 64'd1);
                        @(posedge rdclk); #1;
                        n++;
                        if (acc) bk_cnt++;
                    end
                end
                bk_valid = 1'b0;
                if (!aborted) check_val("busy_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit got;
        int k;
        rden   = 1'b0;
        rdaddr = 64'd0;
        repeat (3) @(posedge rdclk);
        #1;
        check_val("rst_rddata", 64'(rddata), 64'd0);
        check_val("rst_rdhit", 64'(rdhit), 64'd0);
        check_val("rst_bk_req", 64'(bk_req), 64'd0);
        check_val("rst_bk_sector", 64'(bk_sector), 64'd0);
        check_val("rst_bk_ready", 64'(bk_ready), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge rdclk); #1;

        // Cold miss on sector 0, then prefetch of sector 1 once sector 0 is hit.
        exp_sec_q.push_back(55'd0);
        exp_sec_q.push_back(55'd1);
        cycle_rd(64'd0, 1'b0, got);
        check_val("first_miss", 64'(got), 64'd0);
        check_val("req0", 64'(bk_req), 64'd1);
        check_val("sec0", 64'(bk_sector), 64'd0);
        rd_wait(64'd0, 64'd0, 1'b0);
        rd_wait(64'd5, 64'd0, 1'b0);
        check_val("byte5", 64'(rddata), 64'h05);

        // Sequential sector 1 with prefetch of sector 2 (gapped stream).
        gaps = 1'b1;
        exp_sec_q.push_back(55'd2);
        rd_wait(64'h200, 64'd0, 1'b0);
        check_val("pf2_req", 64'(bk_req), 64'd1);
        check_val("pf2_sec", 64'(bk_sector), 64'd2);
        for (int a = 'h201; a <= 'h3FF; a++) cycle_rd(64'(a), 1'b1, got);

        exp_sec_q.push_back(55'd3);
        rd_wait(64'h400, 64'd0, 1'b0);
        check_val("busy_pf3", 64'(busy), 64'd1);

        // Demand miss on sector 9 during the sector-3 prefetch must wait.
        cycle_rd(64'h1207, 1'b0, got);
        check_val("miss9_busy", 64'(got), 64'd0);
        check_val("sec_hold3", 64'(bk_sector), 64'd3);
        for (int j = 1; j < SECTOR_BYTES; j++) cycle_rd(64'h400 + 64'(j), 1'b1, got);
        gaps = 1'b0;
        exp_sec_q.push_back(55'd9);
        exp_sec_q.push_back(55'd10);
        rd_wait(64'h1207, 64'h403, 1'b1);
        check_val("pf10_sec", 64'(bk_sector), 64'd10);
        wait_idle();

        // All-ones sector, prefetch wraps to sector 0.
        exp_sec_q.push_back({SEC_W{1'b1}});
        exp_sec_q.push_back(55'd0);
        rd_wait(64'hFFFF_FFFF_FFFF_FE03, 64'd0, 1'b0);
        check_val("wrap_req", 64'(bk_req), 64'd1);
        check_val("wrap_sec", 64'(bk_sector), 64'd0);
        exp_sec_q.push_back(55'd1);
        rd_wait(64'd5, 64'd0, 1'b0);

        // Reset in the middle of the sector-1 prefetch.
        k = 0;
        while (!(bk_ready && bk_cnt == 100) && k < 4000) begin
            @(posedge rdclk); #1;
            k++;
        end
        check_val("reach_byte100", 64'(bk_cnt), 64'd100);
        rst = 1'b1;
        #1;
        check_val("mid_rst_rddata", 64'(rddata), 64'd0);
        check_val("mid_rst_rdhit", 64'(rdhit), 64'd0);
        check_val("mid_rst_bk_req", 64'(bk_req), 64'd0);
        check_val("mid_rst_bk_sector", 64'(bk_sector), 64'd0);
        check_val("mid_rst_bk_ready", 64'(bk_ready), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge rdclk);
        #1;
        check_val("rst_hold_ready", 64'(bk_ready), 64'd0);
        rst = 1'b0;
        @(posedge rdclk); #1;

        exp_sec_q.push_back(55'd1);
        exp_sec_q.push_back(55'd2);
        cycle_rd(64'h209, 1'b0, got);
        check_val("no_stale_hit", 64'(got), 64'd0);
        check_val("rereq", 64'(bk_req), 64'd1);
        check_val("rereq_sec", 64'(bk_sector), 64'd1);
        rd_wait(64'h209, 64'd0, 1'b0);
        wait_idle();
        repeat (4) @(posedge rdclk);
        #1;

        check_val("sec_q_left", 64'(exp_sec_q.size()), 64'd0);
        check_val("sb_q_left", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
